// File: rtl/rvfi_check_sched_pkg.sv
// Shared types and helpers for the RVFI check sequencer.
package rvfi_sched_pkg;

    localparam int unsigned RETCNT_W = 16;
    localparam int unsigned ORDER_W  = 64;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE,
        EXPIRED
    } sched_state_t;

    // Add two counter values, clamping at all-ones instead of wrapping.
    function automatic logic [RETCNT_W-1:0] sat_add(input logic [RETCNT_W-1:0] a,
                                                     input logic [RETCNT_W-1:0] b);
        logic [RETCNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[RETCNT_W] ? '1 : sum[RETCNT_W-1:0];
    endfunction

endpackage

// File: rtl/rvfi_check_sched_if.sv
// Retirement-side inputs and checker-side outputs of the check sequencer.
interface rvfi_check_sched_if
    import rvfi_sched_pkg::*;
#(
    parameter int unsigned NRET    = 1,
    parameter int unsigned CYCLE_W = 5
);
    logic [NRET-1:0]         rvfi_valid;
    logic [ORDER_W*NRET-1:0] rvfi_order;
    logic                    check;
    logic [ORDER_W-1:0]      check_order;
    logic [RETCNT_W-1:0]     retired_cnt;
    logic [CYCLE_W-1:0]      cycle_cnt;
    logic                    done;
    logic                    expired;

    modport master (
        output rvfi_valid, rvfi_order,
        input  check, check_order, retired_cnt, cycle_cnt, done, expired
    );

    modport slave (
        input  rvfi_valid, rvfi_order,
        output check, check_order, retired_cnt, cycle_cnt, done, expired
    );
endinterface

// File: rtl/rvfi_valid_popcount.sv
// Number of retirement channels reporting a valid instruction this cycle.
module rvfi_valid_popcount #(
    parameter int unsigned NRET = 1
) (
    input  logic [NRET-1:0]              valid,
    output logic [$clog2(NRET+1)-1:0]    count
);
    localparam int unsigned CNT_W = $clog2(NRET + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(NRET); i++) begin
            count = count + CNT_W'(valid[i]);
        end
    end
endmodule

// File: rtl/rvfi_check_sched.sv
// Picks the single cycle in which an attached RVFI checker fires, or flags
// that the bounded window closed without one.
module rvfi_check_sched
    import rvfi_sched_pkg::*;
#(
    parameter int unsigned NRET        = 1,
    parameter int unsigned CHANNEL_IDX = 0,
    parameter int unsigned MIN_CYCLE   = 1,
    parameter int unsigned MIN_RET     = 1,
    parameter int unsigned DEPTH       = 20
) (
    input logic               clock,
    input logic               reset,
    rvfi_check_sched_if.slave bus
);
    localparam int unsigned CYCLE_W = $clog2(DEPTH + 1);
    localparam int unsigned POP_W   = $clog2(NRET + 1);

    if (CHANNEL_IDX >= NRET) begin : g_bad_channel
        $error("CHANNEL_IDX must be smaller than NRET");
    end
    if (MIN_CYCLE >= DEPTH) begin : g_bad_window
        $error("MIN_CYCLE must be smaller than DEPTH");
    end

    sched_state_t        state;
    logic [CYCLE_W-1:0]  cycle_cnt;
    logic [RETCNT_W-1:0] retired_cnt;
    logic                done;
    logic                expired;
    logic [POP_W-1:0]    pop_cnt;
    logic                fire;

    rvfi_valid_popcount #(.NRET(NRET)) u_popcount (
        .valid (bus.rvfi_valid),
        .count (pop_cnt)
    );

    // Retirements of the current cycle are only seen through retired_cnt next cycle.
    always_comb begin
        fire = !reset
            && (state == ARMED)
            && bus.rvfi_valid[CHANNEL_IDX]
            && (cycle_cnt >= CYCLE_W'(MIN_CYCLE))
            && (retired_cnt >= RETCNT_W'(MIN_RET))
            && (cycle_cnt < CYCLE_W'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            done        <= 1'b0;
            expired     <= 1'b0;
        end else begin
            if (cycle_cnt != CYCLE_W'(DEPTH)) begin
                cycle_cnt <= cycle_cnt + CYCLE_W'(1);
            end
            retired_cnt <= sat_add(retired_cnt, RETCNT_W'(pop_cnt));

            // A fire on the closing cycle takes priority over expiry.
            unique case (state)
                IDLE: state <= ARMED;
                ARMED: begin
                    if (fire) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (cycle_cnt == CYCLE_W'(DEPTH - 1)) begin
                        state   <= EXPIRED;
                        expired <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.check       = fire;
    assign bus.check_order = fire ? bus.rvfi_order[CHANNEL_IDX*ORDER_W +: ORDER_W] : '0;
    assign bus.retired_cnt = retired_cnt;
    assign bus.cycle_cnt   = cycle_cnt;
    assign bus.done        = done;
    assign bus.expired     = expired;
endmodule

// File: tb/tb_rvfi_check_sched.sv
// Three sequencer configurations driven side by side and compared each cycle
// against a window/once-per-reset reference model.
module tb_rvfi_check_sched;
    import rvfi_sched_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // a: basic window, b: short window, c: two channels with retirement gating
    rvfi_check_sched_if #(.NRET(1), .CYCLE_W(5)) if_a ();
    rvfi_check_sched_if #(.NRET(1), .CYCLE_W(3)) if_b ();
    rvfi_check_sched_if #(.NRET(2), .CYCLE_W(5)) if_c ();

    rvfi_check_sched #(.NRET(1), .CHANNEL_IDX(0), .MIN_CYCLE(1), .MIN_RET(1), .DEPTH(20))
        dut_a (.clock(clock), .reset(reset), .bus(if_a));
    rvfi_check_sched #(.NRET(1), .CHANNEL_IDX(0), .MIN_CYCLE(1), .MIN_RET(1), .DEPTH(5))
        dut_b (.clock(clock), .reset(reset), .bus(if_b));
    rvfi_check_sched #(.NRET(2), .CHANNEL_IDX(1), .MIN_CYCLE(2), .MIN_RET(3), .DEPTH(20))
        dut_c (.clock(clock), .reset(reset), .bus(if_c));

    int m_nret [3] = '{1, 1, 2};
    int m_ch   [3] = '{0, 0, 1};
    int m_minc [3] = '{1, 1, 2};
    int m_minr [3] = '{1, 1, 3};
    int m_depth[3] = '{20, 5, 20};

    int m_cyc [3];
    int m_ret [3];
    bit m_fired[3];

    logic [1:0]  v  [3];
    logic [63:0] ord[3][2];

    logic        o_check[3];
    logic [63:0] o_order[3];
    logic [15:0] o_ret  [3];
    logic [15:0] o_cyc  [3];
    logic        o_done [3];
    logic        o_exp  [3];

    assign if_a.rvfi_valid = v[0][0];
    assign if_a.rvfi_order = ord[0][0];
    assign if_b.rvfi_valid = v[1][0];
    assign if_b.rvfi_order = ord[1][0];
    assign if_c.rvfi_valid = v[2];
    assign if_c.rvfi_order = {ord[2][1], ord[2][0]};

    assign o_check[0] = if_a.check;   assign o_order[0] = if_a.check_order;
    assign o_check[1] = if_b.check;   assign o_order[1] = if_b.check_order;
    assign o_check[2] = if_c.check;   assign o_order[2] = if_c.check_order;
    assign o_ret[0]   = if_a.retired_cnt;
    assign o_ret[1]   = if_b.retired_cnt;
    assign o_ret[2]   = if_c.retired_cnt;
    assign o_cyc[0]   = 16'(if_a.cycle_cnt);
    assign o_cyc[1]   = 16'(if_b.cycle_cnt);
    assign o_cyc[2]   = 16'(if_c.cycle_cnt);
    assign o_done[0]  = if_a.done;    assign o_exp[0] = if_a.expired;
    assign o_done[1]  = if_b.done;    assign o_exp[1] = if_b.expired;
    assign o_done[2]  = if_c.done;    assign o_exp[2] = if_c.expired;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    // Drive one cycle, compare at the falling edge, then advance the model.
    task automatic step(input logic rst, input logic [1:0] va, input logic [1:0] vb,
                        input logic [1:0] vc);
        reset = rst;
        v[0] = va;
        v[1] = vb;
        v[2] = vc;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 2; j++)
                ord[k][j] = {$urandom, $urandom};
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            int          pop;
            bit          ec;
            logic [63:0] eo;
            pop = int'(v[k][0]) + ((m_nret[k] == 2) ? int'(v[k][1]) : 0);
            // One fire per reset, inside [max(1,MIN_CYCLE), DEPTH) once enough retired.
            ec = !rst && (m_cyc[k] >= 1) && !m_fired[k] && (v[k][m_ch[k]] == 1'b1)
                 && (m_cyc[k] >= m_minc[k]) && (m_ret[k] >= m_minr[k])
                 && (m_cyc[k] < m_depth[k]);
            eo = ec ? ord[k][m_ch[k]] : 64'd0;
            chk($sformatf("check%0d", k),   64'(o_check[k]), 64'(ec));
            chk($sformatf("order%0d", k),   o_order[k],      eo);
            chk($sformatf("retired%0d", k), 64'(o_ret[k]),   64'(m_ret[k]));
            chk($sformatf("cycle%0d", k),   64'(o_cyc[k]),   64'(m_cyc[k]));
            chk($sformatf("done%0d", k),    64'(o_done[k]),  64'(m_fired[k]));
            chk($sformatf("expired%0d", k), 64'(o_exp[k]),
                64'(!m_fired[k] && (m_cyc[k] >= m_depth[k])));
            if (rst) begin
                m_cyc[k]   = 0;
                m_ret[k]   = 0;
                m_fired[k] = 1'b0;
            end else begin
                if (ec) m_fired[k] = 1'b1;
                m_ret[k] = (m_ret[k] + pop > 65535) ? 65535 : m_ret[k] + pop;
                m_cyc[k] = (m_cyc[k] + 1 > m_depth[k]) ? m_depth[k] : m_cyc[k] + 1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int dens;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v[k] = '0;
            ord[k][0] = '0;
            ord[k][1] = '0;
            m_cyc[k] = 0;
            m_ret[k] = 0;
            m_fired[k] = 1'b0;
        end
        @(posedge clock);
        #1;
        step(1'b1, 2'b00, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00);

        // Basic fire on a, closing-cycle tie on b, multi-channel gating on c.
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'b01, (i == 2 || i == 4) ? 2'b01 : 2'b00,
                 (i < 3) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b00));

        // Silent window: b expires, counters saturate.
        step(1'b1, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 9; i++) step(1'b0, 2'b00, 2'b00, 2'b00);

        // Reset lands on a cycle where c would otherwise fire, then it refires.
        step(1'b1, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 2'b00, 2'b01);
        step(1'b1, 2'b01, 2'b01, 2'b10);
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'b00, 2'b00, (i < 3) ? 2'b01 : 2'b10);

        // Random traffic with varying density and occasional resets.
        dens = 4;
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] va, vb, vc;
            if (i % 50 == 0) dens = $urandom_range(0, 8);
            va = {1'b0, 1'($urandom_range(0, 7) < dens)};
            vb = {1'b0, 1'($urandom_range(0, 7) < dens)};
            vc = {1'($urandom_range(0, 7) < dens), 1'($urandom_range(0, 7) < dens)};
            step(1'($urandom_range(0, 39) == 0), va, vb, vc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
